// File: rtl/cmp_serial_pkg.sv
// cmp_pkg: shared FSM state and one-hot result types for the serial comparator
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } cmp_state_t;

    typedef struct packed {
        logic lt;
        logic eq;
        logic gt;
    } cmp_result_t;

endpackage

// File: rtl/cmp_serial_chunk.sv
// cmp_chunk: unsigned less-than / equality compare of one W-bit chunk
module cmp_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_chunk,
    input  logic [W-1:0] b_chunk,
    output logic         lt,
    output logic         eq
);

    assign lt = a_chunk < b_chunk;
    assign eq = a_chunk == b_chunk;

endmodule

// File: rtl/cmp_serial.sv
// cmp_serial: handshaked MSB-first magnitude comparator, W bits per cycle; CMP_SERIAL_EARLY_EXIT_EN stops at the first differing chunk
module cmp_serial
    import cmp_pkg::*;
#(
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         is_signed,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         lt,
    output logic         eq,
    output logic         gt
);

    localparam int C = N / W;
    localparam int KW = (C > 1) ? $clog2(C) : 1;
    localparam logic [KW-1:0] K_TOP = KW'(C - 1);

    cmp_state_t   state;
    logic [N-1:0] a_q;
    logic [N-1:0] b_q;
    logic         sgn_q;
    logic [KW-1:0] k;
    cmp_result_t  res;
    cmp_result_t  cur;
    logic [W-1:0] a_chunk;
    logic [W-1:0] b_chunk;
    logic [W-1:0] msk;
    logic         c_lt;
    logic         c_eq;
`ifndef CMP_SERIAL_EARLY_EXIT_EN
    cmp_result_t  pend;
`endif

    // select chunk k; flipping the sign bit of the top chunk turns two's-complement order into unsigned order
    always_comb begin
        msk = (sgn_q && k == K_TOP) ? W'(1) << (W - 1) : '0;
        a_chunk = a_q[k*W +: W] ^ msk;
        b_chunk = b_q[k*W +: W] ^ msk;
        cur = '{lt: c_lt, eq: c_eq, gt: !c_lt && !c_eq};
    end

    cmp_chunk #(.W(W)) u_chunk (
        .a_chunk(a_chunk),
        .b_chunk(b_chunk),
        .lt     (c_lt),
        .eq     (c_eq)
    );

    // accept, walk chunks MSB-first, hold the result until the consumer takes it
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            res       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            sgn_q     <= 1'b0;
            k         <= '0;
`ifndef CMP_SERIAL_EARLY_EXIT_EN
            pend      <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_q      <= a;
                    b_q      <= b;
                    sgn_q    <= is_signed;
                    k        <= K_TOP;
                    in_ready <= 1'b0;
                    state    <= BUSY;
`ifndef CMP_SERIAL_EARLY_EXIT_EN
                    pend     <= '0;
`endif
                end
                BUSY: begin
`ifdef CMP_SERIAL_EARLY_EXIT_EN
                    if (!c_eq || k == '0) begin
                        res       <= cur;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        k <= k - 1'b1;
                    end
`else
                    if (!c_eq && pend == '0) pend <= cur;
                    if (k == '0) begin
                        res       <= (pend != '0) ? pend : cur;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        k <= k - 1'b1;
                    end
`endif
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    res       <= '0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign lt = res.lt;
    assign eq = res.eq;
    assign gt = res.gt;

endmodule

// File: tb/tb_cmp_serial.sv
// tb_cmp_serial: scoreboard bench for cmp_serial (N=32, W=8), latency expectations follow CMP_SERIAL_EARLY_EXIT_EN
module tb_cmp_serial;

    localparam int N = 32;
    localparam int W = 8;
    localparam int C = N / W;

    typedef struct {
        logic [2:0] res;
        int         lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         is_signed = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         lt;
    logic         eq;
    logic         gt;

    int   total = 0;
    int   passed = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    cmp_serial #(.N(N), .W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .is_signed(is_signed),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .lt       (lt),
        .eq       (eq),
        .gt       (gt)
    );

    function automatic logic [2:0] model_res(input logic [N-1:0] x, input logic [N-1:0] y, input logic s);
        logic l;
        l = s ? ($signed(x) < $signed(y)) : (x < y);
        return (x == y) ? 3'b010 : (l ? 3'b100 : 3'b001);
    endfunction

    function automatic int model_lat(input logic [N-1:0] x, input logic [N-1:0] y);
        int lat;
        lat = C;
`ifdef CMP_SERIAL_EARLY_EXIT_EN
        for (int j = 0; j < C; j++)
            if (x[j*W +: W] != y[j*W +: W]) lat = C - j;
`endif
        return lat;
    endfunction

    task automatic run_op(input string nm, input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                          input logic ts, input int hold);
        exp_t e;
        int   cyc;
        logic [2:0] r0;
        e.res = model_res(ta, tb_v, ts);
        e.lat = model_lat(ta, tb_v);
        total++;
        if (in_ready !== 1'b1) $display("FAIL %s in_ready before accept: got %b want 1", nm, in_ready);
        else passed++;
        sb.push_back(e);
        in_valid = 1'b1; a = ta; b = tb_v; is_signed = ts;
        @(posedge clk); #1;
        in_valid = 1'b0; a = $urandom; b = $urandom; is_signed = $urandom_range(0, 1);
        cyc = 0;
        while (cyc < 3 * C) begin
            @(posedge clk); #1;
            cyc++;
            if (out_valid) break;
        end
        e = sb.pop_front();
        total++;
        if (out_valid !== 1'b1) $display("FAIL %s timeout: out_valid=%b after %0d cycles", nm, out_valid, cyc);
        else passed++;
        total++;
        if (cyc !== e.lat) $display("FAIL %s latency: got %0d want %0d", nm, cyc, e.lat);
        else passed++;
        total++;
        if ({lt, eq, gt} !== e.res) $display("FAIL %s result lt/eq/gt: got %b want %b", nm, {lt, eq, gt}, e.res);
        else passed++;
        r0 = {lt, eq, gt};
        for (int i = 0; i < hold; i++) begin
            if (i == 1) begin in_valid = 1'b1; a = ~ta; b = ~tb_v; end
            if (i == 2) in_valid = 1'b0;
            @(posedge clk); #1;
            total++;
            if ({out_valid, in_ready, lt, eq, gt} !== {2'b10, r0})
                $display("FAIL %s hold cycle %0d: out_valid/in_ready/res got %b want %b", nm, i,
                         {out_valid, in_ready, lt, eq, gt}, {2'b10, r0});
            else passed++;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++;
        if ({out_valid, in_ready, lt, eq, gt} !== 5'b01000)
            $display("FAIL %s release: out_valid/in_ready/res got %b want 01000", nm, {out_valid, in_ready, lt, eq, gt});
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        total++;
        if ({in_ready, out_valid, lt, eq, gt} !== 5'b10000)
            $display("FAIL reset state: in_ready/out_valid/res got %b want 10000", {in_ready, out_valid, lt, eq, gt});
        else passed++;
    endtask

    task automatic test_directed();
        run_op("zero_eq", 32'h0, 32'h0, 1'b0, 0);
        run_op("msb_uns", 32'h8000_0000, 32'h0000_0001, 1'b0, 0);
        run_op("msb_sgn", 32'h8000_0000, 32'h0000_0001, 1'b1, 0);
        run_op("neg1_sgn", 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 0);
        run_op("neg1_uns", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
        run_op("low_lt", 32'h1234_5677, 32'h1234_5678, 1'b0, 0);
        run_op("mid_gt", 32'h1235_0000, 32'h1234_FFFF, 1'b1, 0);
        run_op("eq_sgn", 32'h8000_0000, 32'h8000_0000, 1'b1, 0);
    endtask

    task automatic test_hold();
        run_op("hold", 32'h0000_1000, 32'h0000_0FFF, 1'b0, 5);
        repeat (3) begin
            @(posedge clk); #1;
            total++;
            if ({in_ready, out_valid} !== 2'b10)
                $display("FAIL hold no_accept: in_ready/out_valid got %b want 10", {in_ready, out_valid});
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; a = 32'h1234_5677; b = 32'h1234_5678; is_signed = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if ({in_ready, out_valid, lt, eq, gt} !== 5'b10000)
            $display("FAIL reset_mid state: in_ready/out_valid/res got %b want 10000", {in_ready, out_valid, lt, eq, gt});
        else passed++;
        for (int i = 0; i < 2 * C; i++) begin
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b0) $display("FAIL reset_mid aborted out_valid cycle %0d: got %b want 0", i, out_valid);
            else passed++;
        end
        run_op("after_rst", 32'hFFFF_FF00, 32'h0000_00FF, 1'b1, 0);
    endtask

    task automatic test_random();
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        logic         rs;
        for (int i = 0; i < 200; i++) begin
            ra = $urandom;
            rb = (i % 4 == 0) ? ra ^ (N'(1) << $urandom_range(0, N - 1)) : (i % 7 == 0) ? ra : $urandom;
            rs = $urandom_range(0, 1);
            run_op("random", ra, rb, rs, 0);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
